axi4_lite_cfg_seq: RTL and testbench

AXI4-Lite master that walks a fixed table of register writes after reset, or on request, to configure the design's AXI4-Lite register slaves without CPU involvement. Each table entry is one write (address, data, byte strobes). When compiled in, an optional read-back compare checks each write. The block sits in front of the interconnect, or directly on a slave's s_axi_* ports, and reports busy/done/error plus the index of the failing entry.

---
 rtl/axi4_lite_cfg_pkg.sv | 29 ++
 rtl/axi4_lite_cfg_rom.sv | 11 +
 rtl/axi4_lite_cfg_seq.sv | 200 ++++++++++++++++++++
 tb/tb_axi4_lite_cfg_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_cfg_pkg.sv
// axi4_lite_cfg_pkg: shared states, response codes, entry layout and the fixed configuration table
package axi4_lite_cfg_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_NEXT, S_DONE, S_ERROR
  } state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int ENTRY_ADDR_W = 8;
  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_STRB_W = 4;
  localparam int TABLE_LEN = 8;
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_STRB_W-1:0] strb;
  } cfg_entry_t;
  localparam cfg_entry_t CFG_TABLE [TABLE_LEN] = '{
    '{addr: 8'h00, data: 32'h0000_0001, strb: 4'b1111},
    '{addr: 8'h04, data: 32'hA5A5_1234, strb: 4'b0011},
    '{addr: 8'h08, data: 32'hDEAD_BEEF, strb: 4'b1111},
    '{addr: 8'h0C, data: 32'h1234_5678, strb: 4'b1100},
    '{addr: 8'h10, data: 32'hCAFE_F00D, strb: 4'b1111},
    '{addr: 8'h14, data: 32'h0000_00FF, strb: 4'b0001},
    '{addr: 8'h18, data: 32'h8000_0000, strb: 4'b1000},
    '{addr: 8'h1C, data: 32'h5555_AAAA, strb: 4'b1111}
  };
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
endpackage

// File: rtl/axi4_lite_cfg_rom.sv
// axi4_lite_cfg_rom: combinational table lookup, entries past the table read as all zeros
module axi4_lite_cfg_rom
  import axi4_lite_cfg_pkg::*;
(
  input  logic [3:0]              idx,
  output logic [ENTRY_ADDR_W-1:0] addr,
  output logic [ENTRY_DATA_W-1:0] data,
  output logic [ENTRY_STRB_W-1:0] strb
);
  assign {addr, data, strb} = idx[3] ? '0 : CFG_TABLE[idx[2:0]];
endmodule

// File: rtl/axi4_lite_cfg_seq.sv
// axi4_lite_cfg_seq: AXI4-Lite master replaying a fixed write table; define AXI4_LITE_CFG_SEQ_VERIFY_EN for read-back compare
module axi4_lite_cfg_seq
  import axi4_lite_cfg_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int NUM_ENTRIES    = 8,
  parameter int AUTO_START     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [3:0]           err_index,
  output logic [ADDR_BITS-1:0] m_axi_awaddr,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic [ADDR_BITS-1:0] m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready
);
  state_t state;
  logic [3:0] idx;
  logic [7:0] wait_cnt;
  logic aw_done, w_done, auto_pend, to_hit, aw_fire, w_fire;
  logic [ENTRY_ADDR_W-1:0] rom_addr;
  logic [ENTRY_DATA_W-1:0] rom_data;
  logic [ENTRY_STRB_W-1:0] rom_strb;
  axi4_lite_cfg_rom u_rom (.idx(idx), .addr(rom_addr), .data(rom_data), .strb(rom_strb));
  assign to_hit  = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign aw_fire = m_axi_awvalid & m_axi_awready;
  assign w_fire  = m_axi_wvalid & m_axi_wready;
`ifdef AXI4_LITE_CFG_SEQ_VERIFY_EN
  logic rd_bad;
  assign rd_bad = m_axi_rresp != RESP_OKAY ||
                  ((m_axi_rdata ^ m_axi_wdata) & strb_mask(m_axi_wstrb)) != '0;
`else
  logic unused_rd;
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
  assign unused_rd     = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      wait_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      auto_pend     <= AUTO_START != 0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
`ifdef AXI4_LITE_CFG_SEQ_VERIFY_EN
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`endif
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start || auto_pend) begin
            state     <= S_FETCH;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            auto_pend <= 1'b0;
          end
        end
        S_FETCH: begin
          m_axi_awaddr  <= ADDR_BITS'(rom_addr);
          m_axi_wdata   <= rom_data;
          m_axi_wstrb   <= rom_strb;
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
          state         <= S_WR_REQ;
        end
        S_WR_REQ: begin
          m_axi_awvalid <= m_axi_awvalid & ~m_axi_awready & ~to_hit;
          m_axi_wvalid  <= m_axi_wvalid & ~m_axi_wready & ~to_hit;
          aw_done       <= aw_done | aw_fire;
          w_done        <= w_done | w_fire;
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            state        <= S_WR_RESP;
            m_axi_bready <= 1'b1;
          end else if (to_hit) begin
            state     <= S_ERROR;
            error     <= 1'b1;
            err_index <= idx;
            busy      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != RESP_OKAY) begin
              state     <= S_ERROR;
              error     <= 1'b1;
              err_index <= idx;
              busy      <= 1'b0;
            end else begin
`ifdef AXI4_LITE_CFG_SEQ_VERIFY_EN
              state         <= S_RD_REQ;
              m_axi_araddr  <= m_axi_awaddr;
              m_axi_arvalid <= 1'b1;
`else
              state <= S_NEXT;
`endif
            end
          end else if (to_hit) begin
            m_axi_bready <= 1'b0;
            state        <= S_ERROR;
            error        <= 1'b1;
            err_index    <= idx;
            busy         <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
`ifdef AXI4_LITE_CFG_SEQ_VERIFY_EN
        S_RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD_RESP;
          end else if (to_hit) begin
            m_axi_arvalid <= 1'b0;
            state         <= S_ERROR;
            error         <= 1'b1;
            err_index     <= idx;
            busy          <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (rd_bad) begin
              state     <= S_ERROR;
              error     <= 1'b1;
              err_index <= idx;
              busy      <= 1'b0;
            end else begin
              state <= S_NEXT;
            end
          end else if (to_hit) begin
            m_axi_rready <= 1'b0;
            state        <= S_ERROR;
            error        <= 1'b1;
            err_index    <= idx;
            busy         <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
`endif
        S_NEXT: begin
          if (idx == 4'(NUM_ENTRIES - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + 4'd1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_cfg_seq.sv
// tb_axi4_lite_cfg_seq: table-driven and randomized checks of the config sequencer against a bench-side slave and outcome model
module tb_axi4_lite_cfg_seq;
  localparam int N  = 3;
  localparam int TO = 20;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, error;
  logic [3:0] err_index;
  logic [7:0] awaddr, araddr;
  logic [31:0] wdata, rdata = '0;
  logic [3:0] wstrb;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  always #5 clk = ~clk;
  axi4_lite_cfg_seq #(.ADDR_BITS(8), .NUM_ENTRIES(N), .AUTO_START(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error), .err_index(err_index),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );
  typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] s; } ent_t;
  typedef struct { int aw; int w; int b; int e; bit exp_done; bit exp_err; int exp_idx; int exp_n; } vec_t;
  ent_t tbl [N];
  vec_t vecs [6];
  int compared = 0, mismatched = 0;
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, err_at = -1, ovr_at = -1;
  logic [31:0] ovr_val = '0;
  bit rnd = 0, stall_aw = 0, clr = 0;
  int n_aw, n_w, n_b, n_ar, n_r, aw_wait, w_wait, b_wait, aw_lat, w_lat, b_lat;
  bit b_hs, r_hs, proto_bad, saw_rd;
  logic [7:0] got_a [$];
  logic [31:0] got_d [$];
  logic [3:0] got_s [$];
  function automatic int pick(input int c);
    return rnd ? int'($urandom_range(0, 4)) : c;
  endfunction
  always @(negedge clk) begin
    if (clr) begin
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      aw_lat = pick(cfg_aw); w_lat = pick(cfg_w); b_lat = pick(cfg_b);
      got_a.delete(); got_d.delete(); got_s.delete();
      proto_bad = 0; saw_rd = 0;
    end
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; b_hs = 0;
      arready = 0; rvalid = 0; r_hs = 0;
    end else begin
      if (awvalid && n_aw > n_b) proto_bad = 1;
      if (arvalid || rready) saw_rd = 1;
      if (b_hs) begin bvalid = 0; b_hs = 0; end
      if (!bvalid && n_aw > n_b && n_w > n_b) begin
        if (b_wait >= b_lat) begin bvalid = 1; bresp = (n_b == err_at) ? 2'b10 : 2'b00; end
        else b_wait++;
      end
      if (bvalid && bready) begin b_hs = 1; n_b++; b_wait = 0; b_lat = pick(cfg_b); end
      awready = awvalid && !stall_aw && aw_wait >= aw_lat;
      if (awvalid && !awready) aw_wait++;
      if (awvalid && awready) begin got_a.push_back(awaddr); n_aw++; aw_wait = 0; aw_lat = pick(cfg_aw); end
      wready = wvalid && w_wait >= w_lat;
      if (wvalid && !wready) w_wait++;
      if (wvalid && wready) begin got_d.push_back(wdata); got_s.push_back(wstrb); n_w++; w_wait = 0; w_lat = pick(cfg_w); end
`ifdef AXI4_LITE_CFG_SEQ_VERIFY_EN
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      if (!rvalid && n_ar > n_r) begin
        rvalid = 1; rresp = 2'b00;
        rdata = (n_r == ovr_at) ? ovr_val : got_d[got_d.size()-1];
      end
      if (rvalid && rready) begin r_hs = 1; n_r++; end
      arready = arvalid;
      if (arvalid) begin n_ar++; if (araddr !== got_a[got_a.size()-1]) proto_bad = 1; end
`endif
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_slave(input int aw, input int w, input int b, input int e);
    cfg_aw = aw; cfg_w = w; cfg_b = b; err_at = e;
    clr = 1;
    @(posedge clk);
    @(posedge clk);
    clr = 0;
    @(negedge clk);
  endtask
  task automatic pulse_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_end(input string name);
    int k = 0;
    while (!(done || error) && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) begin
      compared++; mismatched++;
      $display("FAIL %s: no done/error within 400 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic check_run(input string name, input int exp_n, input bit exp_done, input bit exp_err, input int exp_idx);
    chk($sformatf("%s done", name), 32'(done), 32'(exp_done));
    chk($sformatf("%s error", name), 32'(error), 32'(exp_err));
    chk($sformatf("%s err_index", name), 32'(err_index), 32'(exp_idx));
    chk($sformatf("%s busy", name), 32'(busy), 32'd0);
    chk($sformatf("%s awvalid", name), 32'(awvalid), 32'd0);
    chk($sformatf("%s b_count", name), 32'(n_b), 32'(exp_n));
    chk($sformatf("%s aw_count", name), 32'(got_a.size()), 32'(exp_n));
    chk($sformatf("%s protocol", name), 32'(proto_bad), 32'd0);
    for (int i = 0; i < got_a.size() && i < N && i < got_d.size(); i++) begin
      chk($sformatf("%s addr[%0d]", name, i), 32'(got_a[i]), 32'(tbl[i].a));
      chk($sformatf("%s data[%0d]", name, i), got_d[i], tbl[i].d);
      chk($sformatf("%s strb[%0d]", name, i), 32'(got_s[i]), 32'(tbl[i].s));
    end
`ifndef AXI4_LITE_CFG_SEQ_VERIFY_EN
    chk($sformatf("%s no_read", name), 32'(saw_rd), 32'd0);
`endif
  endtask
  initial begin
    int e, k;
    tbl[0] = '{8'h00, 32'h0000_0001, 4'b1111};
    tbl[1] = '{8'h04, 32'hA5A5_1234, 4'b0011};
    tbl[2] = '{8'h08, 32'hDEAD_BEEF, 4'b1111};
    vecs[0] = '{0, 2, 2, -1, 1, 0, 0, 3};
    vecs[1] = '{3, 0, 1, -1, 1, 0, 0, 3};
    vecs[2] = '{0, 0, 0, 2, 0, 1, 2, 3};
    vecs[3] = '{1, 1, 0, -1, 1, 0, 0, 3};
    vecs[4] = '{2, 4, 3, 0, 0, 1, 0, 1};
    vecs[5] = '{0, 1, 0, 1, 0, 1, 1, 2};
    clear_slave(0, 2, 2, -1);
    repeat (2) @(negedge clk);
    chk("rst awvalid", 32'(awvalid), 32'd0);
    chk("rst wvalid", 32'(wvalid), 32'd0);
    chk("rst bready", 32'(bready), 32'd0);
    chk("rst awaddr", 32'(awaddr), 32'd0);
    chk("rst wdata", wdata, 32'd0);
    chk("rst wstrb", 32'(wstrb), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst err_index", 32'(err_index), 32'd0);
    chk("rst arvalid", 32'(arvalid), 32'd0);
    chk("rst rready", 32'(rready), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("auto busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("auto awvalid", 32'(awvalid), 32'd1);
    chk("auto awaddr", 32'(awaddr), 32'(tbl[0].a));
    wait_end("auto");
    check_run("auto", N, 1, 0, 0);
    for (int v = 0; v < 6; v++) begin
      clear_slave(vecs[v].aw, vecs[v].w, vecs[v].b, vecs[v].e);
      pulse_start;
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d awvalid", v), 32'(awvalid), 32'd1);
      wait_end($sformatf("vec%0d", v));
      check_run($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_idx);
    end
    clear_slave(2, 2, 2, -1);
    pulse_start;
    repeat (6) @(negedge clk);
    pulse_start;
    wait_end("busy_start");
    check_run("busy_start", N, 1, 0, 0);
    rnd = 1;
    for (int r = 0; r < 20; r++) begin
      e = int'($urandom_range(0, 3)) - 1;
      clear_slave(0, 0, 0, e);
      pulse_start;
      wait_end($sformatf("rnd%0d", r));
      check_run($sformatf("rnd%0d", r), e < 0 ? N : e + 1, e < 0, e >= 0, e < 0 ? 0 : e);
    end
    rnd = 0;
    stall_aw = 1;
    clear_slave(0, 0, 0, -1);
    pulse_start;
    @(negedge clk);
    k = 0;
    while (awvalid && k < 100) begin k++; @(negedge clk); end
    chk("timeout awvalid cycles", 32'(k), 32'(TO));
    chk("timeout error", 32'(error), 32'd1);
    chk("timeout err_index", 32'(err_index), 32'd0);
    chk("timeout done", 32'(done), 32'd0);
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout wvalid", 32'(wvalid), 32'd0);
    chk("timeout bready", 32'(bready), 32'd0);
    clear_slave(0, 0, 0, -1);
    pulse_start;
    @(negedge clk);
    chk("rstmid awvalid before", 32'(awvalid), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("rstmid awvalid", 32'(awvalid), 32'd0);
    chk("rstmid wvalid", 32'(wvalid), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    stall_aw = 0;
    clear_slave(1, 1, 1, -1);
    rst = 0;
    wait_end("rstmid");
    check_run("rstmid", N, 1, 0, 0);
`ifdef AXI4_LITE_CFG_SEQ_VERIFY_EN
    ovr_at = 1;
    ovr_val = 32'hFFFF_1234;
    clear_slave(0, 0, 0, -1);
    pulse_start;
    wait_end("rb_pass");
    check_run("rb_pass", N, 1, 0, 0);
    chk("rb_pass reads", 32'(n_r), 32'(N));
    ovr_val = 32'h0000_1235;
    clear_slave(0, 0, 0, -1);
    pulse_start;
    wait_end("rb_fail");
    check_run("rb_fail", 2, 0, 1, 1);
    chk("rb_fail reads", 32'(n_r), 32'd2);
    ovr_at = -1;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
